// File: rtl/muldiv_sequencer_if.sv
// Issue/result bundle between the MIPS controller and the multiply/divide sequencer.
// master = controller side, slave = sequencer side.
interface muldiv_sequencer_if;
    logic        start;
    logic [2:0]  op;
    logic [31:0] srca;
    logic [31:0] srcb;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (output start, op, srca, srcb, input busy, done, hi, lo);
    modport slave  (input start, op, srca, srcb, output busy, done, hi, lo);
endinterface

// File: rtl/muldiv_sequencer.sv
// Multi-cycle MULT/MULTU/DIV/DIVU/MTHI/MTLO unit with its own HI/LO pair.
// Optional MULDIV_FAST_MULT_EN: single-cycle combinational multiply, MUL state removed.
module muldiv_sequencer #(
    parameter int unsigned ITER = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clk_enable,
    muldiv_sequencer_if.slave  bus
);

    localparam int unsigned W     = 32;
    localparam int unsigned CNT_W = 6;

    localparam logic [1:0] S_IDLE = 2'd0;
`ifndef MULDIV_FAST_MULT_EN
    localparam logic [1:0] S_MUL  = 2'd1;
`endif
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_FIX  = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [2*W-1:0]   acc_q, acc_d;
    logic [W-1:0]     a_q, a_d, b_q, b_d;
    logic [W-1:0]     hi_q, hi_d, lo_q, lo_d;
    logic             busy_q, busy_d, done_q, done_d;
    logic             negq_q, negq_d, negr_q, negr_d;
    logic             is_div_q, is_div_d, div0_q, div0_d;

    logic             op_signed;
    logic [W-1:0]     abs_a, abs_b;
    logic [2*W-1:0]   mul_raw, mul_fix;
    logic [2*W:0]     div_shift;
    logic [W+1:0]     div_diff;
    logic [2*W-1:0]   div_step;
`ifndef MULDIV_FAST_MULT_EN
    logic [W:0]       mul_sum;
    logic [2*W-1:0]   mul_step;
`endif

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

    // Signed ops work on magnitudes; sign is restored in FIX.
    always_comb begin
        op_signed = ~bus.op[0];
        abs_a     = (op_signed && bus.srca[W-1]) ? -bus.srca : bus.srca;
        abs_b     = (op_signed && bus.srcb[W-1]) ? -bus.srcb : bus.srcb;
    end

    // One shift-add multiply step and one restoring-divide step per edge.
    always_comb begin
`ifdef MULDIV_FAST_MULT_EN
        mul_raw   = {{W{1'b0}}, a_q} * {{W{1'b0}}, b_q};
`else
        mul_sum   = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, a_q} : {(W+1){1'b0}});
        mul_step  = {mul_sum, acc_q[W-1:1]};
        mul_raw   = acc_q;
`endif
        mul_fix   = negq_q ? -mul_raw : mul_raw;
        div_shift = {acc_q, 1'b0};
        div_diff  = {1'b0, div_shift[2*W:W]} - {2'b00, b_q};
        div_step  = div_diff[W+1] ? div_shift[2*W-1:0]
                                  : {div_diff[W-1:0], div_shift[W-1:1], 1'b1};
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        acc_d    = acc_q;
        a_d      = a_q;
        b_d      = b_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        busy_d   = busy_q;
        done_d   = done_q;
        negq_d   = negq_q;
        negr_d   = negr_q;
        is_div_d = is_div_q;
        div0_d   = div0_q;

        if (clk_enable) begin
            done_d = 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        case (bus.op)
                            3'b000, 3'b001, 3'b010, 3'b011: begin
                                a_d      = abs_a;
                                b_d      = abs_b;
                                negq_d   = op_signed & (bus.srca[W-1] ^ bus.srcb[W-1]);
                                negr_d   = op_signed & bus.srca[W-1];
                                is_div_d = bus.op[1];
                                div0_d   = bus.op[1] && (bus.srcb == '0);
                                count_d  = '0;
                                busy_d   = 1'b1;
                                if (bus.op[1]) begin
                                    acc_d   = {{W{1'b0}}, abs_a};
                                    state_d = S_DIV;
                                end else begin
                                    acc_d   = {{W{1'b0}}, abs_b};
`ifdef MULDIV_FAST_MULT_EN
                                    state_d = S_FIX;
`else
                                    state_d = S_MUL;
`endif
                                end
                            end
                            3'b100:  hi_d = bus.srca;
                            3'b101:  lo_d = bus.srca;
                            default: ;
                        endcase
                    end
                end
`ifndef MULDIV_FAST_MULT_EN
                S_MUL: begin
                    if (count_q == CNT_W'(ITER)) begin
                        state_d = S_FIX;
                    end else begin
                        acc_d   = mul_step;
                        count_d = count_q + 1'b1;
                    end
                end
`endif
                S_DIV: begin
                    if (count_q == CNT_W'(ITER)) begin
                        state_d = S_FIX;
                    end else begin
                        acc_d   = div_step;
                        count_d = count_q + 1'b1;
                    end
                end
                S_FIX: begin
                    if (is_div_q) begin
                        lo_d = div0_q ? {W{1'b1}}
                                      : (negq_q ? -acc_q[W-1:0] : acc_q[W-1:0]);
                        hi_d = negr_q ? -acc_q[2*W-1:W] : acc_q[2*W-1:W];
                    end else begin
                        hi_d = mul_fix[2*W-1:W];
                        lo_d = mul_fix[W-1:0];
                    end
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            count_q  <= '0;
            acc_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            negq_q   <= 1'b0;
            negr_q   <= 1'b0;
            is_div_q <= 1'b0;
            div0_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            acc_q    <= acc_d;
            a_q      <= a_d;
            b_q      <= b_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            negq_q   <= negq_d;
            negr_q   <= negr_d;
            is_div_q <= is_div_d;
            div0_q   <= div0_d;
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Bench for muldiv_sequencer: arithmetic/latency reference model checked every cycle,
// directed cases with literal results, then randomized issue/stall/reset traffic.
module tb_muldiv_sequencer;

    logic clk;
    logic reset;
    logic clk_enable;

    muldiv_sequencer_if bus();

    muldiv_sequencer #(.ITER(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .clk_enable (clk_enable),
        .bus        (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

`ifdef MULDIV_FAST_MULT_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 34;
`endif
    localparam int DIV_LAT = 34;

    int n_vec = 0;
    int n_err = 0;
    bit chk_on = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Architectural result {hi,lo} of a MULT/DIV-class op.
    function automatic logic [63:0] calc(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
        longint          sa, sb;
        longint unsigned ua, ub;
        int              ia, ib, q, r;
        case (op)
            3'b000: begin
                sa = $signed(a);
                sb = $signed(b);
                return 64'(sa * sb);
            end
            3'b001: begin
                ua = 64'(a);
                ub = 64'(b);
                return ua * ub;
            end
            default: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                if (op == 3'b011) return {a % b, a / b};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
                ia = a;
                ib = b;
                q  = ia / ib;
                r  = ia % ib;
                return {32'(r), 32'(q)};
            end
        endcase
    endfunction

    // Reference model: a result lands after a fixed number of enabled edges.
    logic        m_busy, m_done;
    logic [31:0] m_hi, m_lo;
    logic [63:0] m_res;
    int          m_left;

    initial begin
        m_busy = 0; m_done = 0; m_hi = 0; m_lo = 0; m_res = 0; m_left = 0;
    end

    always @(posedge clk) begin
        if (reset) begin
            m_busy = 0; m_done = 0; m_hi = 0; m_lo = 0; m_left = 0;
        end else if (clk_enable) begin
            m_done = 0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_hi   = m_res[63:32];
                    m_lo   = m_res[31:0];
                    m_busy = 0;
                    m_done = 1;
                end
            end else if (bus.start) begin
                case (bus.op)
                    3'b000, 3'b001: begin
                        m_res = calc(bus.op, bus.srca, bus.srcb); m_left = MUL_LAT; m_busy = 1;
                    end
                    3'b010, 3'b011: begin
                        m_res = calc(bus.op, bus.srca, bus.srcb); m_left = DIV_LAT; m_busy = 1;
                    end
                    3'b100:  m_hi = bus.srca;
                    3'b101:  m_lo = bus.srca;
                    default: ;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("busy", 32'(bus.busy), 32'(m_busy));
            chk("done", 32'(bus.done), 32'(m_done));
            chk("hi",   bus.hi, m_hi);
            chk("lo",   bus.lo, m_lo);
        end
    end

    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        bus.start = 1'b1;
        bus.op    = o;
        bus.srca  = a;
        bus.srcb  = b;
        @(negedge clk);
        bus.start = 1'b0;
        bus.srca  = $urandom;
        bus.srcb  = $urandom;
    endtask

    task automatic wait_done(output int busy_cycles);
        int n = 0;
        busy_cycles = 0;
        while (bus.done !== 1'b1 && n < 300) begin
            if (bus.busy === 1'b1) busy_cycles++;
            @(negedge clk);
            n++;
        end
        n_vec++;
        if (bus.done !== 1'b1) begin
            n_err++;
            $display("FAIL done_timeout @%0t: got no done after %0d cycles, expected a done pulse", $time, n);
        end
    endtask

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int bc, bc2;
        reset      = 1'b1;
        clk_enable = 1'b1;
        bus.start  = 1'b0;
        bus.op     = 3'b000;
        bus.srca   = 32'h0;
        bus.srcb   = 32'h0;
        repeat (2) @(negedge clk);
        chk_on = 1'b1;
        chk("reset_busy", 32'(bus.busy), 32'd0);
        chk("reset_done", 32'(bus.done), 32'd0);
        chk("reset_hi", bus.hi, 32'd0);
        chk("reset_lo", bus.lo, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        issue(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(bc);
        chk("multu_hi", bus.hi, 32'hFFFF_FFFE);
        chk("multu_lo", bus.lo, 32'h0000_0001);
        chk("multu_busy_cycles", 32'(bc), 32'(MUL_LAT));
        @(negedge clk);
        chk("multu_done_one_cycle", 32'(bus.done), 32'd0);

        issue(3'b000, 32'hFFFF_FFFD, 32'd7);
        wait_done(bc);
        chk("mult_hi", bus.hi, 32'hFFFF_FFFF);
        chk("mult_lo", bus.lo, 32'hFFFF_FFEB);

        issue(3'b010, 32'hFFFF_FFF9, 32'd2);
        wait_done(bc);
        chk("div_lo", bus.lo, 32'hFFFF_FFFD);
        chk("div_hi", bus.hi, 32'hFFFF_FFFF);
        chk("div_busy_cycles", 32'(bc), 32'd34);

        issue(3'b011, 32'd100, 32'd0);
        wait_done(bc);
        chk("divu0_lo", bus.lo, 32'hFFFF_FFFF);
        chk("divu0_hi", bus.hi, 32'h0000_0064);

        issue(3'b010, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(bc);
        chk("div_ovf_lo", bus.lo, 32'h8000_0000);
        chk("div_ovf_hi", bus.hi, 32'h0000_0000);

        issue(3'b011, 32'd10, 32'd3);
        repeat (3) @(negedge clk);
        issue(3'b100, 32'h1234_5678, 32'd0);
        wait_done(bc);
        chk("mthi_busy_hi", bus.hi, 32'd1);
        chk("mthi_busy_lo", bus.lo, 32'd3);

        // Back-to-back: MTLO accepted on the done cycle.
        issue(3'b101, 32'hA5A5_A5A5, 32'd0);
        chk("mtlo_lo", bus.lo, 32'hA5A5_A5A5);
        chk("mtlo_busy", 32'(bus.busy), 32'd0);

        issue(3'b011, 32'd1000, 32'd7);
        bc = 1;
        repeat (3) begin
            @(negedge clk);
            if (bus.busy === 1'b1) bc++;
        end
        clk_enable = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (bus.busy === 1'b1) bc++;
        end
        clk_enable = 1'b1;
        @(negedge clk);
        wait_done(bc2);
        chk("stall_lo", bus.lo, 32'd142);
        chk("stall_hi", bus.hi, 32'd6);
        chk("stall_busy_cycles", 32'(bc + bc2), 32'd39);

        issue(3'b001, 32'hDEAD_BEEF, 32'h1234_5678);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_hi", bus.hi, 32'd0);
        chk("abort_lo", bus.lo, 32'd0);
        issue(3'b001, 32'd6, 32'd7);
        wait_done(bc);
        chk("after_abort_lo", bus.lo, 32'd42);
        chk("after_abort_hi", bus.hi, 32'd0);
        chk("after_abort_busy_cycles", 32'(bc), 32'(MUL_LAT));

        // Random traffic: issues while busy, unknown ops, stalls, rare resets.
        for (int i = 0; i < 3000; i++) begin
            reset      = ($urandom_range(0, 399) == 0);
            clk_enable = ($urandom_range(0, 7) != 0);
            bus.start  = ($urandom_range(0, 2) == 0);
            bus.op     = 3'($urandom_range(0, 7));
            bus.srca   = rnd_operand();
            bus.srcb   = rnd_operand();
            @(negedge clk);
        end
        reset      = 1'b0;
        clk_enable = 1'b1;
        bus.start  = 1'b0;
        repeat (40) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
